// File: rtl/bcd_countdown_timer.sv
// Cascaded modulo-N countdown timer with load, start, pause and a one-cycle done pulse.
// All state, including every output, is registered on clkIn with a synchronous active-low reset.
module bcd_countdown_timer #(
  parameter int DIGITS = 4,
  parameter int MODULO = 10
) (
  input  logic                             clkIn,
  input  logic                             resetIn,
  input  logic                             tickIn,
  input  logic                             loadIn,
  input  logic [DIGITS*$clog2(MODULO)-1:0] loadValueIn,
  input  logic                             startIn,
  input  logic                             pauseIn,
  output logic [DIGITS*$clog2(MODULO)-1:0] countOut,
  output logic                             runningOut,
  output logic                             doneOut
);

  localparam int W  = $clog2(MODULO);
  localparam int CW = DIGITS * W;
  localparam logic [W-1:0]  MAX_DIGIT  = W'(MODULO - 1);
  localparam logic [W-1:0]  ZERO_DIGIT = {W{1'b0}};
  localparam logic [W-1:0]  ONE_DIGIT  = W'(1);
  localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        stateR, stateNextS;
  logic [CW-1:0] countR, countNextS, loadClampS, countDecS;
  logic          doneR, doneNextS, runningR, borrowS;

  // Clamp every loaded digit into the legal range 0..MODULO-1.
  always_comb begin
    loadClampS = ZERO_COUNT;
    for (int i = 0; i < DIGITS; i++) begin
      if (loadValueIn[W*i +: W] > MAX_DIGIT) begin
        loadClampS[W*i +: W] = MAX_DIGIT;
      end else begin
        loadClampS[W*i +: W] = loadValueIn[W*i +: W];
      end
    end
  end

  // Ripple-borrow decrement: a digit moves only while every lower digit was zero.
  always_comb begin
    countDecS = countR;
    borrowS   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrowS) begin
        if (countR[W*i +: W] == ZERO_DIGIT) begin
          countDecS[W*i +: W] = MAX_DIGIT;
        end else begin
          countDecS[W*i +: W] = countR[W*i +: W] - ONE_DIGIT;
          borrowS             = 1'b0;
        end
      end else begin
        countDecS[W*i +: W] = countR[W*i +: W];
      end
    end
  end

  // Next-state and next-output selection; load overrides every state.
  always_comb begin
    stateNextS = stateR;
    countNextS = countR;
    doneNextS  = 1'b0;
    if (loadIn) begin
      stateNextS = IDLE;
      countNextS = loadClampS;
    end else begin
      case (stateR)
        IDLE: begin
          if (startIn && (countR != ZERO_COUNT)) stateNextS = RUN;
          else                                   stateNextS = IDLE;
        end
        RUN: begin
          if (pauseIn) begin
            stateNextS = PAUSE;
          end else if (tickIn) begin
            // Zero in RUN is unreachable; stop rather than wrap to the maximum.
            if (countR == ZERO_COUNT) begin
              stateNextS = DONE;
            end else if (countDecS == ZERO_COUNT) begin
              countNextS = countDecS;
              stateNextS = DONE;
              doneNextS  = 1'b1;
            end else begin
              countNextS = countDecS;
              stateNextS = RUN;
            end
          end else begin
            stateNextS = RUN;
          end
        end
        PAUSE: begin
          if (startIn) stateNextS = RUN;
          else         stateNextS = PAUSE;
        end
        DONE: begin
          stateNextS = DONE;
          countNextS = ZERO_COUNT;
        end
        default: begin
          stateNextS = IDLE;
          countNextS = ZERO_COUNT;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      stateR   <= IDLE;
      countR   <= ZERO_COUNT;
      runningR <= 1'b0;
      doneR    <= 1'b0;
    end else begin
      stateR   <= stateNextS;
      countR   <= countNextS;
      runningR <= (stateNextS == RUN);
      doneR    <= doneNextS;
    end
  end

  assign countOut   = countR;
  assign runningOut = runningR;
  assign doneOut    = doneR;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven bench for bcd_countdown_timer (DIGITS=4, MODULO=10) with a queue scoreboard
// and a decimal reference model for a long countdown sequence.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        resetN, tick, load, start, pause;
  logic [15:0] loadValue, count;
  logic        running, done;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(4), .MODULO(10)) dut (
    .clkIn(clk), .resetIn(resetN), .tickIn(tick), .loadIn(load),
    .loadValueIn(loadValue), .startIn(start), .pauseIn(pause),
    .countOut(count), .runningOut(running), .doneOut(done)
  );

  typedef struct {
    string       tag;
    logic        rstN, tk, ld;
    logic [15:0] lv;
    logic        st, ps;
    logic [15:0] cnt;
    logic        run, dn;
  } vec_t;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        run, dn;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   assertCount = 0;
  int   failCount   = 0;

  function automatic vec_t mk(string tag, logic rstN, logic tk, logic ld, logic [15:0] lv,
                              logic st, logic ps, logic [15:0] cnt, logic run, logic dn);
    vec_t v;
    v.tag = tag; v.rstN = rstN; v.tk = tk; v.ld = ld; v.lv = lv;
    v.st = st; v.ps = ps; v.cnt = cnt; v.run = run; v.dn = dn;
    return v;
  endfunction

  function automatic logic [15:0] toBcd(int n);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((n / 1000) % 10);
    d2 = 4'((n / 100) % 10);
    d1 = 4'((n / 10) % 10);
    d0 = 4'(n % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(string tag, logic rstN, logic tk, logic ld, logic [15:0] lv,
                      logic st, logic ps, logic [15:0] cnt, logic run, logic dn);
    exp_t e;
    @(negedge clk);
    resetN = rstN; tick = tk; load = ld; loadValue = lv; start = st; pause = ps;
    e.tag = tag; e.cnt = cnt; e.run = run; e.dn = dn;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({e.tag, " count"}, count, e.cnt);
    check({e.tag, " running"}, {15'd0, running}, {15'd0, e.run});
    check({e.tag, " done"}, {15'd0, done}, {15'd0, e.dn});
    for (int i = 0; i < 4; i++) begin
      check({e.tag, " digit range"}, {15'd0, (count[4*i +: 4] < 4'd10)}, 16'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetN = 1'b0; tick = 1'b0; load = 1'b0; loadValue = 16'h0000; start = 1'b0; pause = 1'b0;

    //                 tag            rstN  tk    ld    lv        st    ps    cnt       run   dn
    vecs.push_back(mk("reset",        1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("idle tick",    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("start zero",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("load 0100",    1'b1, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
    vecs.push_back(mk("start 0100",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0));
    vecs.push_back(mk("tick 0099",    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0099, 1'b1, 1'b0));
    vecs.push_back(mk("load 0002",    1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0));
    vecs.push_back(mk("start 0002",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0));
    vecs.push_back(mk("tick 0001",    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0));
    vecs.push_back(mk("tick to zero", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk("done tick a",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("done tick b",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("done start",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("load 0005",    1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0));
    vecs.push_back(mk("start 0005",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b0));
    vecs.push_back(mk("tick 0004",    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0));
    vecs.push_back(mk("pause+tick",   1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0));
    vecs.push_back(mk("paused tk 1",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0));
    vecs.push_back(mk("paused tk 2",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0));
    vecs.push_back(mk("paused tk 3",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0));
    vecs.push_back(mk("pause again",  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0));
    vecs.push_back(mk("resume",       1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0));
    vecs.push_back(mk("tick 0003",    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0));
    vecs.push_back(mk("load FFFF",    1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0));
    vecs.push_back(mk("load 000C",    1'b1, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0));
    vecs.push_back(mk("load A3B7",    1'b1, 1'b1, 1'b1, 16'hA3B7, 1'b1, 1'b0, 16'h9397, 1'b0, 1'b0));
    vecs.push_back(mk("load 1000",    1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0));
    vecs.push_back(mk("start 1000",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b1, 1'b0));
    vecs.push_back(mk("borrow 0999",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0999, 1'b1, 1'b0));
    vecs.push_back(mk("load 0050",    1'b1, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 16'h0050, 1'b0, 1'b0));
    vecs.push_back(mk("start 0050",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0050, 1'b1, 1'b0));
    vecs.push_back(mk("load in run",  1'b1, 1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0));
    vecs.push_back(mk("idle tick 20", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0));
    vecs.push_back(mk("load 0000",    1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("start zero 2", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("reload 1000",  1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0));
    vecs.push_back(mk("start 1000b",  1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b1, 1'b0));
    vecs.push_back(mk("reset in run", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("start post rst",1'b1,1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("tick post rst",1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("load 0001",    1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0));
    vecs.push_back(mk("start 0001",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0));
    vecs.push_back(mk("pulse 0001",   1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk("reset w/ load",1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("reload 0020",  1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0));
    vecs.push_back(mk("start 0020",   1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 1'b1, 1'b0));
    vecs.push_back(mk("tick 0019",    1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0019, 1'b1, 1'b0));
    vecs.push_back(mk("done-pulse rst",1'b1,1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0));

    foreach (vecs[k]) begin
      step(vecs[k].tag, vecs[k].rstN, vecs[k].tk, vecs[k].ld, vecs[k].lv,
           vecs[k].st, vecs[k].ps, vecs[k].cnt, vecs[k].run, vecs[k].dn);
    end

    // Reset on the edge right after the done pulse must clear it.
    step("start 0001b", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    step("pulse 0001b", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step("rst on pulse", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Long countdown through several digit borrows, checked against a decimal model.
    step("load 0123", 1'b1, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);
    step("start 0123", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0123, 1'b1, 1'b0);
    for (int n = 122; n >= 0; n--) begin
      step("model tick", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, toBcd(n), (n != 0), (n == 0));
    end
    step("model after", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    if (sbq.size() != 0) begin
      failCount++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded digits.
REQ-002 SHALL have parameter MODULO, default 10, states per digit; digit width W = $clog2(MODULO).
REQ-003 SHALL have port clkIn, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port resetIn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port tickIn, input, 1, decrement strobe; sampled each edge, one decrement per high cycle.
REQ-006 SHALL have port loadIn, input, 1, load strobe.
REQ-007 SHALL have port loadValueIn, input, DIGITS*W, packed digits; digit i at [W*i+W-1 : W*i], digit 0 least significant.
REQ-008 SHALL have port startIn, input, 1, start/resume strobe.
REQ-009 SHALL have port pauseIn, input, 1, pause strobe.
REQ-010 SHALL have port countOut, output, DIGITS*W, registered current digits, same packing as loadValueIn.
REQ-011 SHALL have port runningOut, output, 1, registered, high exactly while in RUN.
REQ-012 SHALL have port doneOut, output, 1, registered one-cycle pulse on reaching zero.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-014 SHALL apply per-edge priority: reset > loadIn > pauseIn > startIn > tickIn.
REQ-015 SHALL, on loadIn in any state, set each digit to min(loaded digit, MODULO-1), enter IDLE, clear doneOut; tickIn/startIn/pauseIn in that cycle ignored.
REQ-016 SHALL, in IDLE, on startIn with countOut nonzero enter RUN; with countOut zero remain IDLE, no doneOut.
REQ-017 SHALL ignore tickIn in IDLE, PAUSE and DONE; countOut holds.
REQ-018 SHALL, in RUN on tickIn, decrement digit 0; digit i>0 decrements only when all lower digits were 0 before the edge; a digit at 0 that decrements wraps to MODULO-1.
REQ-019 SHALL update countOut on the edge at which tickIn is sampled high (latency one edge, no pipelining).
REQ-020 SHALL, when a RUN tick makes countOut all-zero, enter DONE and assert doneOut during the cycle countOut first reads zero, deasserting it on the next edge.
REQ-021 SHALL, in RUN on pauseIn, enter PAUSE; a tickIn in the same cycle is discarded.
REQ-022 SHALL, in PAUSE on startIn, return to RUN; pauseIn in PAUSE has no effect.
REQ-023 SHALL hold countOut at zero in DONE; startIn and pauseIn ignored; only loadIn or reset leaves DONE.
REQ-024 SHALL never produce a digit value >= MODULO on countOut.
REQ-025 SHALL never underflow below all-zero; no wrap from 0 to the maximum value.

Reset
REQ-026 SHALL, on any edge with resetIn low, force state IDLE, countOut 0, runningOut 0, doneOut 0, regardless of other inputs.
REQ-027 SHALL honour reset mid-RUN or mid-DONE pulse identically; doneOut deasserts at that edge.
REQ-028 SHALL reach no output or state value through any asynchronous path.

Verification (DIGITS=4, MODULO=10; digits written d3d2d1d0)
REQ-029 SHALL cover: load 0100, start, one tick -> countOut 0099, runningOut 1, doneOut 0.
REQ-030 SHALL cover: load 0002, start, tick, tick -> 0001 then 0000 with doneOut high exactly one cycle, runningOut 0; further ticks -> 0000, doneOut stays 0.
REQ-031 SHALL cover: load 0005, start, tick -> 0004; pause with simultaneous tick -> 0004; 3 ticks -> 0004; start, tick -> 0003.
REQ-032 SHALL cover: load raw 0xFFFF -> countOut 9999; load digit 0xC in d0 with others 0 -> 0009.
REQ-033 SHALL cover: in RUN at 0050, loadIn(0020) with tickIn same cycle -> 0020, state IDLE, runningOut 0; start with count 0000 in IDLE -> stays IDLE, no doneOut.
REQ-034 SHALL cover: resetIn low one cycle during RUN at 1000 with tickIn high -> next cycle countOut 0000, runningOut 0, doneOut 0; subsequent start ignored until load.
